pc_fetch_ctrl: RTL and testbench

PC_FETCH_CTRL -- requirements
Module: pc_fetch_ctrl

---
 rtl/cpu_pkg.sv | 5 +
 rtl/pc_fetch_ctrl_if.sv | 22 ++
 rtl/pc_fetch_ctrl_adder.sv | 8 +
 rtl/pc_fetch_ctrl.sv | 60 ++++++
 tb/tb_pc_fetch_ctrl.sv | 100 ++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: fetch state encoding and word size shared by the fetch datapath.
package cpu_pkg;
    typedef enum logic [1:0] {BOOT, RUN, HOLD} fetch_state_e;
    localparam logic [31:0] WORD_BYTES = 32'd4;
endpackage

// File: rtl/pc_fetch_ctrl_if.sv
// pc_fetch_if: control inputs and PC outputs of the fetch controller.
interface pc_fetch_if;
    logic        stall_i;
    logic        branch_i;
    logic        zero_i;
    logic [31:0] offset_sl2_i;
    logic        jump_i;
    logic [25:0] jump_idx_i;
    logic [31:0] pc_o;
    logic [31:0] pc_plus4_o;
    logic        redirect_o;
    logic        misalign_o;
    logic        busy_o;
    modport master (
        output stall_i, branch_i, zero_i, offset_sl2_i, jump_i, jump_idx_i,
        input  pc_o, pc_plus4_o, redirect_o, misalign_o, busy_o
    );
    modport slave (
        input  stall_i, branch_i, zero_i, offset_sl2_i, jump_i, jump_idx_i,
        output pc_o, pc_plus4_o, redirect_o, misalign_o, busy_o
    );
endinterface

// File: rtl/pc_fetch_ctrl_adder.sv
// Adder: 32-bit modulo-2^32 adder, carry out discarded.
module Adder (
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [31:0] y_o
);
    assign y_o = a_i + b_i;
endmodule

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: program counter with boot delay, stall hold and jump/branch redirect.
module pc_fetch_ctrl
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned BOOT_WAIT = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    pc_fetch_if.slave   bus
);
    localparam int unsigned CW = (BOOT_WAIT > 1) ? $clog2(BOOT_WAIT) : 1;
    fetch_state_e state_q;
    logic [31:0]  pc_q, pc_d, pc_plus4, br_target;
    logic [CW-1:0] cnt_q;
    logic         redirect_q, redirect_d, misalign_q, misalign_d, take_br;
    Adder u_pc4 (.a_i(pc_q), .b_i(WORD_BYTES), .y_o(pc_plus4));
    Adder u_br  (.a_i(pc_plus4), .b_i(bus.offset_sl2_i), .y_o(br_target));
    always_comb begin
        take_br    = bus.branch_i & bus.zero_i;
        redirect_d = bus.jump_i | take_br;
        misalign_d = ~bus.jump_i & take_br & (|br_target[1:0]);
        pc_d       = bus.jump_i ? {pc_plus4[31:28], bus.jump_idx_i, 2'b00} :
                     take_br    ? {br_target[31:2], 2'b00} : pc_plus4;
    end
    // BOOT_WAIT of 0 and 1 both leave BOOT on the first edge after release.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= BOOT;
            pc_q       <= RESET_PC;
            cnt_q      <= '0;
            redirect_q <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            redirect_q <= 1'b0;
            case (state_q)
                BOOT: begin
                    if (32'(cnt_q) + 32'd1 >= BOOT_WAIT) state_q <= RUN;
                    else cnt_q <= cnt_q + 1'b1;
                end
                RUN, HOLD: begin
                    if (bus.stall_i) begin
                        state_q <= HOLD;
                    end else begin
                        state_q    <= RUN;
                        pc_q       <= pc_d;
                        redirect_q <= redirect_d;
                        misalign_q <= misalign_q | misalign_d;
                    end
                end
                default: state_q <= BOOT;
            endcase
        end
    end
    assign bus.pc_o       = pc_q;
    assign bus.pc_plus4_o = pc_plus4;
    assign bus.redirect_o = redirect_q;
    assign bus.misalign_o = misalign_q;
    assign bus.busy_o     = (state_q == BOOT);
endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb_pc_fetch_ctrl: directed vector table plus async-reset sequence for pc_fetch_ctrl.
module tb_pc_fetch_ctrl;
    typedef struct {
        logic        st, br, zr, jp;
        logic [31:0] off;
        logic [25:0] idx;
        logic [31:0] pc;
        logic        red, mis, busy;
    } vec_t;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    vec_t tbl[$];
    always #5 clk = ~clk;
    pc_fetch_if bus();
    pc_fetch_ctrl #(.RESET_PC(32'h0), .BOOT_WAIT(1)) dut (.clk_i(clk), .rst_i(rst_n), .bus(bus));

    function automatic vec_t mk(logic st, logic br, logic zr, logic jp, logic [31:0] off,
                                logic [25:0] idx, logic [31:0] pc, logic red, logic mis, logic busy);
        vec_t v;
        v.st = st; v.br = br; v.zr = zr; v.jp = jp; v.off = off; v.idx = idx;
        v.pc = pc; v.red = red; v.mis = mis; v.busy = busy;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expect_out(string tag, logic [31:0] pc, logic red, logic mis, logic busy);
        chk({tag, " pc"}, bus.pc_o, pc);
        chk({tag, " pc_plus4"}, bus.pc_plus4_o, pc + 32'd4);
        chk({tag, " redirect"}, {31'd0, bus.redirect_o}, {31'd0, red});
        chk({tag, " misalign"}, {31'd0, bus.misalign_o}, {31'd0, mis});
        chk({tag, " busy"}, {31'd0, bus.busy_o}, {31'd0, busy});
    endtask

    task automatic drive(vec_t v);
        bus.stall_i = v.st; bus.branch_i = v.br; bus.zero_i = v.zr; bus.jump_i = v.jp;
        bus.offset_sl2_i = v.off; bus.jump_idx_i = v.idx;
    endtask

    initial begin
        tbl.push_back(mk(0,0,0,0, 32'h0,        26'h0,   32'h0000_0000, 0,0,0));
        tbl.push_back(mk(0,0,0,0, 32'h0,        26'h0,   32'h0000_0004, 0,0,0));
        tbl.push_back(mk(0,0,0,0, 32'h0,        26'h0,   32'h0000_0008, 0,0,0));
        tbl.push_back(mk(0,0,0,0, 32'h0,        26'h0,   32'h0000_000C, 0,0,0));
        tbl.push_back(mk(0,0,0,1, 32'h0,        26'h40,  32'h0000_0100, 1,0,0));
        tbl.push_back(mk(0,1,1,0, 32'hFFFF_FFF0, 26'h0,  32'h0000_00F4, 1,0,0));
        tbl.push_back(mk(0,0,0,1, 32'h0,        26'h40,  32'h0000_0100, 1,0,0));
        tbl.push_back(mk(0,1,0,0, 32'hFFFF_FFF0, 26'h0,  32'h0000_0104, 0,0,0));
        tbl.push_back(mk(0,1,1,0, 32'h3FFF_FF08, 26'h0,  32'h4000_0010, 1,0,0));
        tbl.push_back(mk(0,1,1,1, 32'h0000_0100, 26'h40, 32'h4000_0100, 1,0,0));
        tbl.push_back(mk(0,1,1,0, 32'hBFFF_FF1C, 26'h0,  32'h0000_0020, 1,0,0));
        tbl.push_back(mk(1,0,0,1, 32'h0,        26'h123, 32'h0000_0020, 0,0,0));
        tbl.push_back(mk(1,0,0,0, 32'h0,        26'h0,   32'h0000_0020, 0,0,0));
        tbl.push_back(mk(1,1,1,1, 32'h40,       26'h1,   32'h0000_0020, 0,0,0));
        tbl.push_back(mk(0,0,0,0, 32'h0,        26'h0,   32'h0000_0024, 0,0,0));
        tbl.push_back(mk(0,1,1,0, 32'hFFFF_FFD4, 26'h0,  32'hFFFF_FFFC, 1,0,0));
        tbl.push_back(mk(0,0,0,0, 32'h0,        26'h0,   32'h0000_0000, 0,0,0));
        tbl.push_back(mk(0,1,1,1, 32'h6,        26'h3,   32'h0000_000C, 1,0,0));
        tbl.push_back(mk(0,1,1,0, 32'h6,        26'h0,   32'h0000_0014, 1,1,0));
        tbl.push_back(mk(0,0,0,0, 32'h0,        26'h0,   32'h0000_0018, 0,1,0));
        tbl.push_back(mk(0,0,0,1, 32'h0,        26'h20,  32'h0000_0080, 1,1,0));
        tbl.push_back(mk(1,0,0,0, 32'h0,        26'h0,   32'h0000_0080, 0,1,0));
        tbl.push_back(mk(1,1,1,1, 32'h8,        26'h7,   32'h0000_0080, 0,1,0));
        drive(mk(0,0,0,0, 32'h0, 26'h0, 32'h0, 0,0,0));
        #3;
        expect_out("reset", 32'h0, 0, 0, 1);
        @(posedge clk); #1;
        expect_out("reset_held", 32'h0, 0, 0, 1);
        #3 rst_n = 1'b1;
        expect_out("boot0", 32'h0, 0, 0, 1);
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i]);
            @(posedge clk); #1;
            expect_out($sformatf("row%0d", i), tbl[i].pc, tbl[i].red, tbl[i].mis, tbl[i].busy);
        end
        #2 rst_n = 1'b0;
        #1 expect_out("async_rst", 32'h0, 0, 0, 1);
        @(posedge clk); #1;
        expect_out("rst_edge", 32'h0, 0, 0, 1);
        #2 rst_n = 1'b1;
        drive(mk(1,1,1,1, 32'h10, 26'h40, 32'h0, 0,0,0));
        @(posedge clk); #1;
        expect_out("reboot_ignore", 32'h0, 0, 0, 0);
        drive(mk(0,0,0,0, 32'h0, 26'h0, 32'h0, 0,0,0));
        @(posedge clk); #1;
        expect_out("reboot_pc4", 32'h4, 0, 0, 0);
        @(posedge clk); #1;
        expect_out("reboot_pc8", 32'h8, 0, 0, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
